// File: rtl/hilo_mdu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hilo_mdu_pkg
// Description : Shared definitions for the HI/LO multiply/divide unit.
//               Holds the MDU operation codes, the divider state encoding,
//               the default datapath width and a small decode helper.
// Revision    : 1.0 - initial release
// ============================================================================
package hilo_mdu_pkg;

    localparam int MDU_WIDTH = 32;

    localparam logic [2:0] MDU_MULT  = 3'd0;
    localparam logic [2:0] MDU_MULTU = 3'd1;
    localparam logic [2:0] MDU_DIV   = 3'd2;
    localparam logic [2:0] MDU_DIVU  = 3'd3;
    localparam logic [2:0] MDU_MTHI  = 3'd4;
    localparam logic [2:0] MDU_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DIV    = 2'd1,
        ST_FINISH = 2'd2
    } mdu_state_e;

    function automatic logic is_div_op(input logic [2:0] op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

endpackage
`default_nettype wire

// File: rtl/hilo_mdu_div_radix2.sv
`default_nettype none
// ============================================================================
// Module      : div_radix2
// Description : Multi-cycle radix-2 restoring divider (IDLE -> DIV -> FINISH).
//               Operands are converted to magnitudes on start, one quotient
//               bit is produced per DIV cycle, and sign correction plus the
//               divide-by-zero override are applied combinationally while in
//               FINISH.
// Ports       : clk, rst       - clock, synchronous active-high reset
//               start          - begin a divide (taken only in IDLE)
//               cancel         - abort an in-flight divide
//               signed_op      - 1 = signed (DIV), 0 = unsigned (DIVU)
//               a, b           - dividend, divisor
//               ready          - high for the single FINISH cycle
//               quot, rem      - final quotient / remainder (valid on ready)
// Revision    : 1.0 - initial release
// ============================================================================
module div_radix2
    import hilo_mdu_pkg::*;
#(
    parameter int WIDTH     = MDU_WIDTH,
    parameter int DIV_ITERS = WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             cancel,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic [WIDTH-1:0] quot,
    output logic [WIDTH-1:0] rem
);

    localparam int            CW     = (DIV_ITERS > 1) ? $clog2(DIV_ITERS) : 1;
    localparam logic [CW-1:0] c_last = CW'(DIV_ITERS - 1);

    mdu_state_e       r_state;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quot;      // holds the dividend, shifted out as quotient bits shift in
    logic [WIDTH-1:0] r_divisor;
    logic [WIDTH-1:0] r_a;         // raw dividend, returned as remainder on divide by zero
    logic             r_neg_q;
    logic             r_neg_r;
    logic             r_zero;

    logic             w_a_neg;
    logic             w_b_neg;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_diff;

    assign w_a_neg = signed_op & a[WIDTH-1];
    assign w_b_neg = signed_op & b[WIDTH-1];
    assign w_a_mag = w_a_neg ? (-a) : a;
    assign w_b_mag = w_b_neg ? (-b) : b;

    // Partial remainder never exceeds the divisor, so one extra bit is enough
    // to detect a negative trial subtraction.
    assign w_shift = {r_rem, r_quot[WIDTH-1]};
    assign w_diff  = w_shift - {1'b0, r_divisor};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_count   <= '0;
            r_rem     <= '0;
            r_quot    <= '0;
            r_divisor <= '0;
            r_a       <= '0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_zero    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start && !cancel) begin
                        r_state   <= ST_DIV;
                        r_count   <= '0;
                        r_rem     <= '0;
                        r_quot    <= w_a_mag;
                        r_divisor <= w_b_mag;
                        r_a       <= a;
                        r_neg_q   <= w_a_neg ^ w_b_neg;
                        r_neg_r   <= w_a_neg;
                        r_zero    <= (b == '0);
                    end
                end
                ST_DIV: begin
                    if (cancel) begin
                        r_state <= ST_IDLE;
                    end else begin
                        if (!w_diff[WIDTH]) begin
                            r_rem <= w_diff[WIDTH-1:0];
                        end else begin
                            r_rem <= w_shift[WIDTH-1:0];
                        end
                        r_quot  <= {r_quot[WIDTH-2:0], ~w_diff[WIDTH]};
                        r_count <= r_count + CW'(1);
                        if (r_count == c_last) begin
                            r_state <= ST_FINISH;
                        end
                    end
                end
                ST_FINISH: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign ready = (r_state == ST_FINISH);
    assign quot  = r_zero ? {WIDTH{1'b1}} : (r_neg_q ? (-r_quot) : r_quot);
    assign rem   = r_zero ? r_a           : (r_neg_r ? (-r_rem)  : r_rem);

endmodule
`default_nettype wire

// File: rtl/hilo_mdu.sv
`default_nettype none
// ============================================================================
// Module      : hilo_mdu
// Description : Multiply/divide unit owning the architectural HI/LO pair.
//               MULT/MULTU/MTHI/MTLO complete at the accept edge; DIV/DIVU
//               run on div_radix2 and hold the pipeline via busy.
// Ports       : clk, rst       - clock, synchronous active-high reset
//               op_valid, op   - request qualifier and MDU operation code
//               a, b           - rs / rt operands
//               cancel         - flush; blocks accept, aborts a divide
//               busy           - divide in flight
//               done           - one-cycle pulse after HI/LO update
//               hi_o, lo_o     - current HI / LO
// Revision    : 1.0 - initial release
// ============================================================================
module hilo_mdu
    import hilo_mdu_pkg::*;
#(
    parameter int WIDTH     = MDU_WIDTH,
    parameter int DIV_ITERS = WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             op_valid,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_busy;
    logic               r_done;

    logic               w_accept;
    logic               w_start;
    logic               w_div_ready;
    logic [WIDTH-1:0]   w_quot;
    logic [WIDTH-1:0]   w_rem;
    logic [2*WIDTH-1:0] w_prod_s;
    logic [2*WIDTH-1:0] w_prod_u;

    assign w_accept = op_valid & ~r_busy & ~cancel;
    assign w_start  = w_accept & is_div_op(op);

    // Operands are widened before multiplying so the low 2*WIDTH bits of the
    // product are exact for both signednesses.
    assign w_prod_s = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};
    assign w_prod_u = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

    div_radix2 #(
        .WIDTH     (WIDTH),
        .DIV_ITERS (DIV_ITERS)
    ) u_div (
        .clk       (clk),
        .rst       (rst),
        .start     (w_start),
        .cancel    (cancel),
        .signed_op (op == MDU_DIV),
        .a         (a),
        .b         (b),
        .ready     (w_div_ready),
        .quot      (w_quot),
        .rem       (w_rem)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hi   <= '0;
            r_lo   <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                case (op)
                    MDU_MULT: begin
                        {r_hi, r_lo} <= w_prod_s;
                        r_done       <= 1'b1;
                    end
                    MDU_MULTU: begin
                        {r_hi, r_lo} <= w_prod_u;
                        r_done       <= 1'b1;
                    end
                    MDU_DIV, MDU_DIVU: begin
                        r_busy <= 1'b1;
                    end
                    MDU_MTHI: begin
                        r_hi   <= a;
                        r_done <= 1'b1;
                    end
                    MDU_MTLO: begin
                        r_lo   <= a;
                        r_done <= 1'b1;
                    end
                    default: begin
                    end
                endcase
            end
            if (r_busy) begin
                if (cancel) begin
                    r_busy <= 1'b0;
                end else if (w_div_ready) begin
                    r_hi   <= w_rem;
                    r_lo   <= w_quot;
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign hi_o = r_hi;
    assign lo_o = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_hilo_mdu.sv
`default_nettype none
// ============================================================================
// Module      : tb_hilo_mdu
// Description : Directed self-checking bench for hilo_mdu. Inputs change one
//               time unit after the rising edge; outputs are checked there.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hilo_mdu;
    import hilo_mdu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        op_valid;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        cancel;
    logic        busy;
    logic        done;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    int checks   = 0;
    int failures = 0;

    hilo_mdu #(
        .WIDTH     (32),
        .DIV_ITERS (32)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .op_valid (op_valid),
        .op       (op),
        .a        (a),
        .b        (b),
        .cancel   (cancel),
        .busy     (busy),
        .done     (done),
        .hi_o     (hi_o),
        .lo_o     (lo_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one request for a single edge, then drop op_valid.
    task automatic issue(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv);
        op_valid = 1'b1;
        op       = o;
        a        = av;
        b        = bv;
        step();
        op_valid = 1'b0;
    endtask

    // Run a divide: busy must stay high for 33 cycles with no done, then the
    // result appears together with a single done pulse.
    task automatic run_div(input string tag, input logic [2:0] o,
                           input logic [31:0] av, input logic [31:0] bv,
                           input logic [31:0] exp_lo, input logic [31:0] exp_hi,
                           input bit inject);
        int busy_bad = 0;
        int done_bad = 0;
        issue(o, av, bv);
        for (int i = 0; i < 33; i++) begin
            if (busy !== 1'b1) busy_bad++;
            if (done !== 1'b0) done_bad++;
            if (inject && i == 5) begin
                op_valid = 1'b1;
                op       = MDU_MULT;
                a        = 32'd3;
                b        = 32'd3;
                step();
                op_valid = 1'b0;
            end else begin
                step();
            end
        end
        chk({tag, "_busy_cycles"}, busy_bad, 0);
        chk({tag, "_no_early_done"}, done_bad, 0);
        chk({tag, "_busy_drop"}, {31'd0, busy}, 32'd0);
        chk({tag, "_done"}, {31'd0, done}, 32'd1);
        chk({tag, "_lo"}, lo_o, exp_lo);
        chk({tag, "_hi"}, hi_o, exp_hi);
        step();
        chk({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        int done_seen;
        rst = 1'b1; op_valid = 1'b0; op = 3'd0; a = '0; b = '0; cancel = 1'b0;
        step();
        step();
        rst = 1'b0;
        chk("rst_hi", hi_o, 32'd0);
        chk("rst_lo", lo_o, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);

        // MULT -3 * 5 = -15
        issue(MDU_MULT, 32'hFFFF_FFFD, 32'd5);
        chk("mult_hi", hi_o, 32'hFFFF_FFFF);
        chk("mult_lo", lo_o, 32'hFFFF_FFF1);
        chk("mult_done", {31'd0, done}, 32'd1);
        chk("mult_busy", {31'd0, busy}, 32'd0);
        step();
        chk("mult_done_pulse", {31'd0, done}, 32'd0);

        // MULTU (2^32-1)^2 = 0xFFFFFFFE_00000001
        issue(MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        chk("multu_hi", hi_o, 32'hFFFF_FFFE);
        chk("multu_lo", lo_o, 32'h0000_0001);

        issue(MDU_MTHI, 32'h1234_5678, 32'd0);
        chk("mthi_hi", hi_o, 32'h1234_5678);
        chk("mthi_lo", lo_o, 32'h0000_0001);
        chk("mthi_done", {31'd0, done}, 32'd1);

        issue(MDU_MTLO, 32'hCAFE_0001, 32'd0);
        chk("mtlo_lo", lo_o, 32'hCAFE_0001);
        chk("mtlo_hi", hi_o, 32'h1234_5678);

        // Reserved opcode: nothing changes, no done
        issue(3'd6, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        chk("rsvd_hi", hi_o, 32'h1234_5678);
        chk("rsvd_lo", lo_o, 32'hCAFE_0001);
        chk("rsvd_done", {31'd0, done}, 32'd0);

        // DIV -7 / 2 = -3 rem -1, with a MULT presented while busy
        run_div("div_neg", MDU_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b1);

        // Divide by zero
        run_div("divu_zero", MDU_DIVU, 32'd100, 32'd0, 32'hFFFF_FFFF, 32'd100, 1'b0);
        run_div("div_zero", MDU_DIV, 32'hFFFF_FFF0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFF0, 1'b0);

        // Overflow case
        run_div("div_ovf", MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0);

        // Signed mixed: 7 / -2 = -3 rem 1
        run_div("div_mix", MDU_DIV, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0);

        // Unsigned with top bit set: 0x80000000 / 3 = 0x2AAAAAAA rem 2
        run_div("divu_big", MDU_DIVU, 32'h8000_0000, 32'd3, 32'h2AAA_AAAA, 32'd2, 1'b0);

        // Cancel mid-divide
        issue(MDU_MTHI, 32'h0000_AAAA, 32'd0);
        issue(MDU_MTLO, 32'h0000_5555, 32'd0);
        issue(MDU_DIVU, 32'd100, 32'd7);
        for (int i = 1; i < 10; i++) step();
        cancel = 1'b1;
        step();
        cancel = 1'b0;
        chk("cancel_busy", {31'd0, busy}, 32'd0);
        chk("cancel_hi", hi_o, 32'h0000_AAAA);
        chk("cancel_lo", lo_o, 32'h0000_5555);
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (done !== 1'b0) done_seen++;
            step();
        end
        chk("cancel_no_done", done_seen, 0);
        chk("cancel_hi_later", hi_o, 32'h0000_AAAA);
        chk("cancel_lo_later", lo_o, 32'h0000_5555);

        run_div("divu_after_cancel", MDU_DIVU, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);

        // Cancel in IDLE with no request has no effect
        cancel = 1'b1;
        step();
        cancel = 1'b0;
        chk("idle_cancel_hi", hi_o, 32'd2);
        chk("idle_cancel_lo", lo_o, 32'd14);

        // Reset on cycle 5 of a divide
        issue(MDU_DIV, 32'd1000, 32'd3);
        for (int i = 1; i < 5; i++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rstdiv_busy", {31'd0, busy}, 32'd0);
        chk("rstdiv_hi", hi_o, 32'd0);
        chk("rstdiv_lo", lo_o, 32'd0);
        chk("rstdiv_done", {31'd0, done}, 32'd0);
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (done !== 1'b0) done_seen++;
            step();
        end
        chk("rstdiv_no_done", done_seen, 0);
        chk("rstdiv_lo_later", lo_o, 32'd0);

        // cancel beats op_valid
        cancel = 1'b1;
        issue(MDU_MTLO, 32'h0000_BEEF, 32'd0);
        cancel = 1'b0;
        chk("cancel_op_lo", lo_o, 32'd0);
        chk("cancel_op_done", {31'd0, done}, 32'd0);
        cancel = 1'b1;
        issue(MDU_DIVU, 32'd50, 32'd5);
        cancel = 1'b0;
        chk("cancel_div_busy", {31'd0, busy}, 32'd0);

        // Unit still works after all of that
        run_div("divu_final", MDU_DIVU, 32'd50, 32'd5, 32'd10, 32'd0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hilo_mdu.md
Name: hilo_mdu

Overview:
- Multiply/divide unit with the architectural HI/LO register pair; sits in EX beside the ALU.
- Executes the HI/LO-writing instructions that the main decoder flags with HiLoWrite: MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- Multiplies and moves complete in one cycle. Divides run on a multi-cycle radix-2 engine and hold the pipeline through `busy`.
- Supplies the current HI/LO values for MFHI/MFLO.

Parameters:
- WIDTH, 32, operand and HI/LO register width.
- DIV_ITERS, WIDTH, number of restoring-division iterations; must equal WIDTH.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- op_valid  in  1  request qualifier.
- op  in  3  operation code from the shared package: MULT=0, MULTU=1, DIV=2, DIVU=3, MTHI=4, MTLO=5; 6 and 7 are reserved.
- a  in  WIDTH  rs operand; dividend, or the source for MTHI/MTLO.
- b  in  WIDTH  rt operand; divisor.
- cancel  in  1  flush from exception/branch logic; aborts an in-flight divide.
- busy  out  1  divide in flight; pipeline must stall EX.
- done  out  1  one-cycle pulse the cycle after HI/LO is updated.
- hi_o  out  WIDTH  current HI.
- lo_o  out  WIDTH  current LO.

Behaviour:
- Reset: HI=0, LO=0, state IDLE, busy=0, done=0. Reset aborts any divide in progress; HI/LO are cleared, not written with a partial result.
- Accept condition: op_valid & ~busy & ~cancel, sampled at a rising edge. While busy=1, op_valid is ignored.
- MULT/MULTU: at the accept edge {HI,LO} <= the 64-bit product (signed or unsigned); done=1 in the next cycle.
- MTHI/MTLO: at the accept edge HI (or LO) <= a, and the other register is unchanged; done=1 in the next cycle.
- Reserved op codes: no state change, and done stays 0.
- DIV/DIVU state machine, states IDLE -> DIV -> FINISH -> IDLE:
  - Accept edge: latch the operand magnitudes and the sign flags; count <= 0; go to DIV.
  - DIV: one shift-subtract iteration per cycle. After DIV_ITERS cycles go to FINISH.
  - FINISH: apply the sign correction. At the FINISH edge LO <= quotient and HI <= remainder; go to IDLE; done=1 in the following cycle.
  - busy = (state != IDLE), so it is high for exactly 33 cycles (32 in DIV plus 1 in FINISH).
  - HI/LO show the new values 34 cycles after the accept edge.
- Signed arithmetic:
  - Quotient is negative iff the operand signs differ.
  - Remainder takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- Divide by zero (both signednesses):
  - Fixed result: LO=0xFFFFFFFF, HI=a.
  - Same 34-cycle timing as a normal divide; no exception is raised.
- cancel:
  - In DIV or FINISH: return to IDLE at that edge, HI/LO unchanged, done=0.
  - When cancel and op_valid are high in the same cycle, cancel wins and the op is not accepted.
  - In IDLE with no request, cancel has no effect.
- hi_o/lo_o are direct register outputs, with no bypass. A value written at edge N is visible from cycle N+1.

Decomposition:
- Shared package (alongside the existing instruction defines):
  - op code constants MDU_MULT..MDU_MTLO.
  - state encodings IDLE/DIV/FINISH.
  - WIDTH default.
- Sub-module div_radix2 holds:
  - the iteration counter;
  - the partial-remainder and quotient registers;
  - sign handling;
  - the divide-by-zero override.
- Its interface is start/cancel/signed_op/a/b in and ready/quot/rem out.
- hilo_mdu owns the HI/LO registers, the multiplier and the accept/done logic.

Test Plan:
- MULT a=0xFFFFFFFD (-3), b=5 -> next cycle HI=0xFFFFFFFF, LO=0xFFFFFFF1, done=1 for 1 cycle, busy stays 0.
- MULTU a=b=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001. Then MTHI a=0x12345678 -> HI=0x12345678, LO unchanged at 0x00000001.
- DIV a=0xFFFFFFF9 (-7), b=2 -> busy high for 33 cycles; at cycle 34 LO=0xFFFFFFFD, HI=0xFFFFFFFF, done pulses once. An op_valid MULT presented while busy is not executed.
- DIVU a=100, b=0 -> after 34 cycles LO=0xFFFFFFFF, HI=100. DIV a=0x80000000, b=0xFFFFFFFF -> LO=0x80000000, HI=0.
- Start DIVU 100/7 with HI/LO preloaded to 0xAAAA/0x5555; assert cancel on cycle 10 -> busy=0 next cycle, HI/LO stay 0xAAAA/0x5555, done never pulses. A subsequent DIVU 100/7 gives LO=14, HI=2.
- Assert rst on cycle 5 of a divide -> next cycle busy=0, HI=0, LO=0, done=0. cancel and op_valid(MTLO) in the same cycle -> LO unchanged.
